// File: rtl/keypad_clave_entry.sv
// Keypad PIN capture: collects four BCD digits with clear/backspace/enter keys
// and an inactivity timeout, then offers the packed PIN under a valid/ack handshake.
module keypad_clave_entry #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tecla_valida,
  input  logic [3:0]  tecla_codigo,
  input  logic        clave_ack,
  output logic [15:0] clave_ingresada,
  output logic        clave_valida,
  output logic [2:0]  digitos_cnt,
  output logic        senal_timeout,
  output logic        senal_error
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] K_BORRAR = 4'hA;
  localparam logic [3:0] K_RETRO  = 4'hB;
  localparam logic [3:0] K_ENTER  = 4'hC;

  typedef enum logic [1:0] {IDLE, CAPTURA, COMPLETA, ENVIO} state_e;

  state_e        state_q, state_d;
  logic [15:0]   buf_q, buf_d;
  logic [15:0]   pin_q, pin_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tout_q, tout_d;
  logic          err_q, err_d;

  logic key_acc, key_dig;
  assign key_acc = tecla_valida && (tecla_codigo <= K_ENTER);
  assign key_dig = tecla_codigo <= 4'h9;

  // State register and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      pin_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      tout_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      pin_q   <= pin_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      tout_q  <= tout_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    pin_d   = pin_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    tout_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE, CAPTURA, COMPLETA: begin
        // Saturating so it can never wrap back below the limit
        if (state_q != IDLE && tmo_q != TMO_LAST) tmo_d = tmo_q + 1'b1;
        if (key_acc) begin
          tmo_d = '0;
          if (key_dig) begin
            if (state_q != COMPLETA) begin
              buf_d   = {buf_q[11:0], tecla_codigo};
              cnt_d   = cnt_q + 3'd1;
              state_d = (cnt_q == 3'd3) ? COMPLETA : CAPTURA;
            end
          end else if (tecla_codigo == K_BORRAR) begin
            buf_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end else if (tecla_codigo == K_RETRO) begin
            if (state_q != IDLE) begin
              buf_d   = {4'h0, buf_q[15:4]};
              cnt_d   = cnt_q - 3'd1;
              state_d = (cnt_q == 3'd1) ? IDLE : CAPTURA;
            end
          end else begin
            if (state_q == COMPLETA) begin
              pin_d   = buf_q;
              state_d = ENVIO;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
            buf_d = '0;
            cnt_d = '0;
          end
        end else if (state_q != IDLE && tmo_q == TMO_LAST) begin
          buf_d   = '0;
          cnt_d   = '0;
          tout_d  = 1'b1;
          state_d = IDLE;
        end
      end
      ENVIO: begin
        if (clave_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE || state_d == ENVIO) tmo_d = '0;
  end

  // Outputs
  always_comb begin
    clave_ingresada = pin_q;
    clave_valida    = (state_q == ENVIO);
    digitos_cnt     = cnt_q;
    senal_timeout   = tout_q;
    senal_error     = err_q;
  end

endmodule

// File: tb/tb_keypad_clave_entry.sv
// Directed bench for keypad_clave_entry: a queue-based model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_keypad_clave_entry;
  localparam int T = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        tecla_valida = 1'b0;
  logic [3:0]  tecla_codigo = 4'h0;
  logic        clave_ack = 1'b0;
  logic [15:0] clave_ingresada;
  logic        clave_valida;
  logic [2:0]  digitos_cnt;
  logic        senal_timeout;
  logic        senal_error;

  int checks = 0;
  int failures = 0;
  bit done = 0;

  keypad_clave_entry #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .tecla_valida(tecla_valida),
    .tecla_codigo(tecla_codigo), .clave_ack(clave_ack),
    .clave_ingresada(clave_ingresada), .clave_valida(clave_valida),
    .digitos_cnt(digitos_cnt), .senal_timeout(senal_timeout),
    .senal_error(senal_error)
  );

  always #5 clock = ~clock;

  // Model: digits as a queue, a sending flag and a count of idle cycles.
  logic [3:0]  m_q[$];
  bit          m_send;
  logic [15:0] m_pin;
  int          m_since;
  bit          m_to, m_err;

  task automatic model_reset();
    m_q.delete(); m_send = 0; m_pin = 16'h0; m_since = 0; m_to = 0; m_err = 0;
  endtask

  task automatic model_step(input bit v, input logic [3:0] c, input bit ack);
    m_to = 0; m_err = 0;
    if (m_send) begin
      if (ack) m_send = 0;
    end else if (v && c <= 4'hC) begin
      m_since = 0;
      if (c <= 4'h9) begin
        if (m_q.size() < 4) m_q.push_back(c);
      end else if (c == 4'hA) m_q.delete();
      else if (c == 4'hB) begin
        if (m_q.size() > 0) void'(m_q.pop_back());
      end else begin
        if (m_q.size() == 4) begin
          m_pin = {m_q[0], m_q[1], m_q[2], m_q[3]};
          m_send = 1;
        end else m_err = 1;
        m_q.delete();
      end
    end else if (m_q.size() > 0) begin
      m_since++;
      if (m_since == T) begin
        m_to = 1; m_q.delete(); m_since = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) model_reset();
      else model_step(tecla_valida, tecla_codigo, clave_ack);
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (!done) begin
        check("m_pin",     clave_ingresada, m_pin);
        check("m_valid",   {15'h0, clave_valida}, {15'h0, m_send});
        check("m_cnt",     {13'h0, digitos_cnt}, 16'(m_q.size()));
        check("m_timeout", {15'h0, senal_timeout}, {15'h0, m_to});
        check("m_error",   {15'h0, senal_error}, {15'h0, m_err});
      end
    end
  end

  // Stimulus tasks assume the caller sits at a falling edge.
  task automatic key(input logic [3:0] c);
    tecla_valida = 1'b1; tecla_codigo = c;
    @(negedge clock);
    tecla_valida = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_timeout(input string name, input int exp);
    int n;
    n = 0;
    while (!senal_timeout && n < 20) begin
      @(negedge clock);
      n++;
    end
    check(name, 16'(n), 16'(exp));
  endtask

  initial begin
    #1;
    check("reset_pin", clave_ingresada, 16'h0000);
    check("reset_valid", {15'h0, clave_valida}, 16'h0);
    check("reset_cnt", {13'h0, digitos_cnt}, 16'h0);
    idle(2);
    reset = 1'b1;
    idle(1);

    // 1,2,3,4,enter; ack three cycles later
    key(4'h1); key(4'h2); key(4'h3); key(4'h4);
    check("t1_cnt4", {13'h0, digitos_cnt}, 16'd4);
    key(4'hC);
    check("t1_pin", clave_ingresada, 16'h1234);
    check("t1_valid", {15'h0, clave_valida}, 16'h1);
    idle(2);
    check("t1_valid3", {15'h0, clave_valida}, 16'h1);
    clave_ack = 1'b1; idle(1); clave_ack = 1'b0;
    check("t1_drop", {15'h0, clave_valida}, 16'h0);
    check("t1_cnt0", {13'h0, digitos_cnt}, 16'h0);

    // backspace plus ignored fifth digit; ack together with a key drops the key
    key(4'h5); key(4'h6); key(4'hB); key(4'h7); key(4'h8); key(4'h9);
    key(4'h0); key(4'hC);
    check("t2_pin", clave_ingresada, 16'h5789);
    clave_ack = 1'b1; tecla_valida = 1'b1; tecla_codigo = 4'h3;
    idle(1);
    clave_ack = 1'b0; tecla_valida = 1'b0;
    check("t2_keydrop", {13'h0, digitos_cnt}, 16'h0);

    // short enter
    key(4'h1); key(4'h2); key(4'hC);
    check("t3_err", {15'h0, senal_error}, 16'h1);
    check("t3_valid", {15'h0, clave_valida}, 16'h0);
    idle(1);
    check("t3_err_off", {15'h0, senal_error}, 16'h0);

    // inactivity timeout, ignored codes do not restart it
    key(4'h9);
    wait_timeout("t4_to8", T);
    check("t4_cnt0", {13'h0, digitos_cnt}, 16'h0);
    key(4'h9); key(4'hF);
    wait_timeout("t4_to_ign", T - 1);
    // key at cycle 7 restarts the counter
    key(4'h9); idle(6); key(4'h5);
    check("t4_restart", {13'h0, digitos_cnt}, 16'd2);
    wait_timeout("t4_to_re", T);
    // key coinciding with the timeout edge wins
    key(4'h1); idle(7); key(4'h2);
    check("t4_keywin", {13'h0, digitos_cnt}, 16'd2);
    key(4'hA);

    // keys during ENVIO ignored
    key(4'h4); key(4'h3); key(4'h2); key(4'h1); key(4'hC);
    key(4'hA); key(4'h5); key(4'hB); key(4'hC);
    check("t5_hold", clave_ingresada, 16'h4321);
    check("t5_valid", {15'h0, clave_valida}, 16'h1);
    clave_ack = 1'b1; idle(1); clave_ack = 1'b0;
    check("t5_after", clave_ingresada, 16'h4321);
    check("t5_cnt", {13'h0, digitos_cnt}, 16'h0);

    // asynchronous reset during ENVIO
    key(4'h8); key(4'h8); key(4'h8); key(4'h8); key(4'hC);
    #2 reset = 1'b0;
    #1;
    check("t6_valid", {15'h0, clave_valida}, 16'h0);
    check("t6_pin", clave_ingresada, 16'h0000);
    @(negedge clock);
    reset = 1'b1;
    key(4'h7);
    check("t6_first", {13'h0, digitos_cnt}, 16'd1);
    idle(2);

    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end
endmodule
